// File: rtl/sync_fifo_v3_if.sv
// Handshake and status bundle for sync_fifo_v3. The master side is the producer/consumer
// logic driving the FIFO; the slave side is the FIFO itself.
interface sync_fifo_v3_if #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned CntWidth = $clog2(DEPTH) + 1;

  logic                  flush;
  logic                  clr_err;
  logic                  wren;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  rden;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CntWidth-1:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, clr_err, wren, i_data, rden,
    input  o_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, clr_err, wren, i_data, rden,
    output o_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_v3.sv
// Single-clock FIFO with fill count, almost-full/empty flags, optional show-ahead read,
// synchronous flush and sticky overflow/underflow error bits.
module sync_fifo_v3 #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SHOW_AHEAD = 0,
  parameter int unsigned AF_THRESH  = 6,
  parameter int unsigned AE_THRESH  = 1
) (
  input logic           clk,
  input logic           rst_n,
  sync_fifo_v3_if.slave bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);
  localparam logic [CntW-1:0] AfC    = CntW'(AF_THRESH);
  localparam logic [CntW-1:0] AeC    = CntW'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full, empty;
  logic                  rd_ok, wr_ok;

  assign full  = (count_q == DepthC);
  assign empty = (count_q == '0);

  always_comb begin
    rd_ok    = 1'b0;
    wr_ok    = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ok = bus.rden & ~empty;
      // A pop in the same cycle frees the slot, so a write at full still fits.
      wr_ok = bus.wren & (~full | rd_ok);
      if (rd_ok) rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (wr_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(wr_ok) - CntW'(rd_ok);
    end
    // A new error outranks clr_err; flush suppresses error detection.
    overflow_d  = (overflow_q & ~bus.clr_err) | (bus.wren & ~wr_ok & ~bus.flush);
    underflow_d = (underflow_q & ~bus.clr_err) | (bus.rden & empty & ~bus.flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is not reset; the rst_n gate keeps a write from landing during reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) mem_q[wr_ptr_q] <= bus.i_data;
  end

  if (SHOW_AHEAD != 0) begin : g_show_ahead
    assign bus.o_data = mem_q[rd_ptr_q];
  end else begin : g_registered
    logic [DATA_WIDTH-1:0] rdata_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rdata_q <= '0;
      else if (rd_ok) rdata_q <= mem_q[rd_ptr_q];
    end
    assign bus.o_data = rdata_q;
  end

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= AfC);
  assign bus.almost_empty = (count_q <= AeC);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_v3.sv
// Drives a registered-read and a show-ahead sync_fifo_v3 with identical stimulus and
// compares both against a queue-based model of the FIFO.
module tb_sync_fifo_v3;
  localparam int unsigned Depth = 8;
  localparam int unsigned Dw    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          clr_err = 1'b0;
  logic          wren = 1'b0;
  logic          rden = 1'b0;
  logic [Dw-1:0] wdata = '0;

  always #5 clk = ~clk;

  sync_fifo_v3_if #(.DEPTH(Depth), .DATA_WIDTH(Dw)) bus0 ();
  sync_fifo_v3_if #(.DEPTH(Depth), .DATA_WIDTH(Dw)) bus1 ();

  assign bus0.flush   = flush;
  assign bus0.clr_err = clr_err;
  assign bus0.wren    = wren;
  assign bus0.i_data  = wdata;
  assign bus0.rden    = rden;
  assign bus1.flush   = flush;
  assign bus1.clr_err = clr_err;
  assign bus1.wren    = wren;
  assign bus1.i_data  = wdata;
  assign bus1.rden    = rden;

  sync_fifo_v3 #(
    .DEPTH(Depth), .DATA_WIDTH(Dw), .SHOW_AHEAD(0), .AF_THRESH(6), .AE_THRESH(1)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  sync_fifo_v3 #(
    .DEPTH(Depth), .DATA_WIDTH(Dw), .SHOW_AHEAD(1), .AF_THRESH(6), .AE_THRESH(1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  // Reference model
  logic [Dw-1:0] q[$];
  logic [Dw-1:0] exp_o0;
  bit            exp_ovf;
  bit            exp_unf;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    exp_o0  = '0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic check_all();
    int n;
    n = q.size();
    check("count0", 32'(bus0.count), 32'(n));
    check("full0", 32'(bus0.full), 32'(n == Depth));
    check("empty0", 32'(bus0.empty), 32'(n == 0));
    check("afull0", 32'(bus0.almost_full), 32'(n >= 6));
    check("aempty0", 32'(bus0.almost_empty), 32'(n <= 1));
    check("ovf0", 32'(bus0.overflow), 32'(exp_ovf));
    check("unf0", 32'(bus0.underflow), 32'(exp_unf));
    check("odata0", 32'(bus0.o_data), 32'(exp_o0));
    check("count1", 32'(bus1.count), 32'(n));
    check("ovf1", 32'(bus1.overflow), 32'(exp_ovf));
    check("unf1", 32'(bus1.underflow), 32'(exp_unf));
    if (n > 0) check("odata1", 32'(bus1.o_data), 32'(q[0]));
  endtask

  // One clock: apply inputs, advance the model on the edge, compare just after it.
  task automatic step(input bit fl, input bit ce, input bit we, input logic [Dw-1:0] d,
                      input bit re);
    bit rd_ok, wr_ok, ovf_new, unf_new;
    flush   = fl;
    clr_err = ce;
    wren    = we;
    wdata   = d;
    rden    = re;
    @(posedge clk);
    ovf_new = 1'b0;
    unf_new = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      rd_ok   = re && (q.size() > 0);
      wr_ok   = we && ((q.size() < Depth) || rd_ok);
      ovf_new = we && !wr_ok;
      unf_new = re && (q.size() == 0);
      if (rd_ok) exp_o0 = q.pop_front();
      if (wr_ok) q.push_back(d);
    end
    exp_ovf = ovf_new || (exp_ovf && !ce);
    exp_unf = unf_new || (exp_unf && !ce);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    // Reset held with a write pending: nothing may land.
    rst_n = 1'b0;
    wren  = 1'b1;
    wdata = 8'h5C;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    wren  = 1'b0;
    rst_n = 1'b1;
    #1;
    check_all();

    // Fill, overflow, drain, underflow
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'h10 + i), 0);
    step(0, 0, 1, 8'h99, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 8'h00, 1);
    step(0, 0, 0, 8'h00, 1);
    step(0, 1, 0, 8'h00, 0);

    // clr_err together with a fresh overflow
    for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'h20 + i), 0);
    step(0, 1, 1, 8'h77, 0);
    // Simultaneous read/write at full, then drain so 0xAA comes out last
    step(0, 0, 1, 8'hAA, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 8'h00, 1);
    // Simultaneous read/write at empty
    step(0, 1, 0, 8'h00, 0);
    step(0, 0, 1, 8'h33, 1);
    step(0, 1, 0, 8'h00, 0);

    // Flush at count 5 with requests pending
    for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h40 + i), 0);
    step(1, 0, 1, 8'hEE, 1);
    step(0, 0, 0, 8'h00, 0);

    // Show-ahead: data visible without rden, then pop
    step(0, 0, 1, 8'h5A, 0);
    step(0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 8'h00, 1);

    // Steady 3-deep traffic across pointer wrap
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'(8'h60 + i), 0);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 8'(8'h80 + i), 1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50));
    end
    step(0, 0, 0, 8'h00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
